rr_sel_arb: RTL and testbench

Eight-way round-robin arbiter that converts a request vector into a registered 3-bit channel index plus valid flag. It sits directly upstream of the 3-to-8 one-hot decoder stage and supplies that decoder's select input. It holds each grant until the owner signals completion or, optionally, a hold timeout expires. Index encoding is binary, with bit 2 as MSB; sel = 3'b101 selects requester 5.

---
 rtl/rr_sel_pkg.sv | 17 +
 rtl/rr_pick.sv | 30 +++
 rtl/rr_sel_arb.sv | 110 +++++++++++
 tb/tb_rr_sel_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_sel_pkg.sv
// rtl/rr_sel_pkg.sv - shared constants, FSM state type and hold-counter sizing for rr_sel_arb
package rr_sel_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Counter must be able to reach hold_max itself (saturation value)
    function automatic int hold_cnt_w(input int hold_max);
        return $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority finder: first set request above ptr, wrapping
module rr_pick
    import rr_sel_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic             w_found;
    logic [SEL_W-1:0] w_cand;

    // Scan ptr+1, ptr+2, ... ptr+8 (mod 8); the last candidate is ptr itself,
    // so the previous owner only wins when nobody else is asking.
    always_comb begin
        idx     = '0;
        any     = |req;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = ptr + SEL_W'(k);
            if (!w_found && req[w_cand]) begin
                idx     = w_cand;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arb.sv
// rtl/rr_sel_arb.sv - 8-way round-robin arbiter with registered select index; optional hold timeout via RR_SEL_ARB_TIMEOUT_EN
module rr_sel_arb
    import rr_sel_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic             sel_vld,
    output logic             busy,
    output logic             to_err
);

    if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_bad_hold_max
        $error("rr_sel_arb: HOLD_MAX must be in 2..255");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             r_to_err;
    logic             w_to_err_nxt;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_timeout;

    rr_pick u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

`ifdef RR_SEL_ARB_TIMEOUT_EN
    localparam int HOLD_W = hold_cnt_w(HOLD_MAX);

    logic [HOLD_W-1:0] r_cnt;

    // Hold counter: zero while idle so every grant starts from 0, saturating during a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else if (r_cnt != HOLD_W'(HOLD_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Counter reads HOLD_MAX-1 on the edge that closes the HOLD_MAX-th granted cycle
    assign w_timeout = (r_state == ST_GRANT) && (r_cnt == HOLD_W'(HOLD_MAX - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State, pointer, select and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 3'd7;
            r_sel    <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_sel    <= w_sel_nxt;
            r_to_err <= w_to_err_nxt;
        end
    end

    // Next-state logic: grant from IDLE, release on done (wins over timeout)
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_sel_nxt    = r_sel;
        w_to_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_GRANT;
                    w_ptr_nxt   = w_pick_idx;
                    w_sel_nxt   = w_pick_idx;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt  = ST_IDLE;
                    w_to_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sel     = r_sel;
    assign sel_vld = (r_state == ST_GRANT);
    assign busy    = sel_vld;
    assign to_err  = r_to_err;

endmodule

// File: tb/tb_rr_sel_arb.sv
// tb/tb_rr_sel_arb.sv - directed and randomized self-checking bench for rr_sel_arb against a behavioural model
module tb_rr_sel_arb;

    localparam int HOLD_MAX = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic       sel_vld;
    logic       busy;
    logic       to_err;

    int n_assert;
    int n_fail;

    // behavioural model state
    int m_owner;
    int m_last;
    int m_sel;
    int m_len;
    bit m_toerr;

    rr_sel_arb #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .sel_vld (sel_vld),
        .busy    (busy),
        .to_err  (to_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (last + k) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_sel   = 0;
        m_len   = 0;
        m_toerr = 1'b0;
    endtask

    // One rising edge of the reference: grant lengths counted in whole cycles
    task automatic model_step(input logic [7:0] r, input logic d);
        int p;
        m_toerr = 1'b0;
        if (m_owner >= 0) begin
            m_len++;
            if (d) begin
                m_owner = -1;
            end
`ifdef RR_SEL_ARB_TIMEOUT_EN
            else if (m_len == HOLD_MAX) begin
                m_owner = -1;
                m_toerr = 1'b1;
            end
`endif
        end else begin
            p = pick(r, m_last);
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_sel   = p;
                m_len   = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_sel"},     int'(sel),     m_sel);
        check({tag, "_sel_vld"}, int'(sel_vld), (m_owner >= 0) ? 1 : 0);
        check({tag, "_busy"},    int'(busy),    (m_owner >= 0) ? 1 : 0);
        check({tag, "_to_err"},  int'(to_err),  int'(m_toerr));
    endtask

    task automatic step(input string tag, input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input logic [7:0] r);
        req   = r;
        done  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int hi_cnt;
        n_assert = 0;
        n_fail   = 0;
        req      = 8'h00;
        done     = 1'b0;
        rst_n    = 1'b0;
        model_reset();

        // reset with all requesting, then one full rotation 0..7,0
        do_reset(8'hFF);
        step("first", 8'hFF, 1'b0);
        check("first_grant_idx", int'(sel), 0);
        for (int i = 1; i <= 8; i++) begin
            step("rot_rel", 8'hFF, 1'b1);
            check("rot_gap", int'(sel_vld), 0);
            step("rot_grant", 8'hFF, 1'b0);
            check("rot_idx", int'(sel), i % 8);
        end
        step("rot_end", 8'hFF, 1'b1);

        // wrap-around fairness: ptr at 5, requesters 0 and 5 pending -> 0
        step("ptr5_idle", 8'h00, 1'b0);
        step("ptr5_grant", 8'b0010_0000, 1'b0);
        check("ptr5_idx", int'(sel), 5);
        step("ptr5_rel", 8'b0010_0000, 1'b1);
        step("wrap_grant", 8'b0010_0001, 1'b0);
        check("wrap_idx", int'(sel), 0);
        step("wrap_rel", 8'h00, 1'b1);

        // grant to 3, drop request, never send done
        step("to_grant", 8'b0000_1000, 1'b0);
        check("to_idx", int'(sel), 3);
        hi_cnt = 1;
        for (int i = 0; i < 150; i++) begin
            step("to_hold", 8'h00, 1'b0);
            if (!sel_vld) break;
            hi_cnt++;
        end
`ifdef RR_SEL_ARB_TIMEOUT_EN
        check("to_len", hi_cnt, HOLD_MAX);
        check("to_err_pulse", int'(to_err), 1);
        step("to_after", 8'h00, 1'b0);
        check("to_err_clear", int'(to_err), 0);
`else
        check("hold_gt_100", (hi_cnt > 100) ? 1 : 0, 1);
        step("hold_done", 8'h00, 1'b1);
        check("hold_released", int'(sel_vld), 0);
        check("hold_no_err", int'(to_err), 0);
`endif

        // done lands on the timeout edge: done wins, no error pulse
        step("co_grant", 8'b0100_0000, 1'b0);
        for (int i = 0; i < HOLD_MAX - 1; i++) step("co_hold", 8'b0100_0000, 1'b0);
        step("co_rel", 8'b0100_0000, 1'b1);
        check("co_vld", int'(sel_vld), 0);
        check("co_to_err", int'(to_err), 0);

        // asynchronous reset mid-grant
        step("ar_grant", 8'b0001_0000, 1'b0);
        step("ar_hold", 8'b0001_0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_vld_async", int'(sel_vld), 0);
        check("ar_sel_async", int'(sel), 0);
        check("ar_err_async", int'(to_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_first", 8'hFF, 1'b0);
        check("ar_first_idx", int'(sel), 0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            logic       d;
            r = 8'($urandom) & 8'($urandom);
            d = ($urandom_range(0, 5) == 0);
            step("rand", r, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
